code_event_fifo: RTL and testbench

//  Consumes the (idle, code) pair produced by the 8-to-3 priority encoder stage.

---
 rtl/code_event_fifo.sv | 134 +++++++++++++
 tb/tb_code_event_fifo.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/code_event_fifo.sv
// Detects new events in the priority-encoder (idle, code) stream and queues their codes in a
// first-word fall-through FIFO with a valid/ready output. Define CEF_STAMP_EN to add cycle stamps.
module code_event_fifo #(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          idle,
    input  logic [2:0]    code,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [2:0]    out_code,
    output logic          full,
    output logic [AW:0]   count,
    output logic          overflow
`ifdef CEF_STAMP_EN
    ,
    output logic [7:0]    out_stamp
`endif
);

    // Handshake: an entry transfers on a cycle where out_valid and out_ready are both high;
    // out_valid/out_code are registered and never depend on out_ready, idle or code.
    logic [2:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_inc;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    out_code_q, out_code_d;
    logic          prev_idle_q;
    logic [2:0]    prev_code_q;
    logic          overflow_q;
    logic          ev, push, pop;

    assign full       = (count_q == (AW+1)'(DEPTH));
    assign count      = count_q;
    assign out_valid  = (count_q != '0);
    assign out_code   = out_code_q;
    assign overflow   = overflow_q;
    assign rd_ptr_inc = rd_ptr_q + 1'b1;

    assign ev   = !idle && (prev_idle_q || (code != prev_code_q));
    assign pop  = out_valid && out_ready;
    assign push = ev && (!full || pop);

    always_comb begin
        count_d = count_q;
        if (push && !pop)
            count_d = count_q + 1'b1;
        else if (pop && !push)
            count_d = count_q - 1'b1;
    end

    // The head register tracks what mem[rd_ptr] will hold after this edge; when the
    // FIFO drains it keeps the last value handed out.
    always_comb begin
        out_code_d = out_code_q;
        if (count_q == '0) begin
            if (push)
                out_code_d = code;
        end else if (pop) begin
            if (count_q > (AW+1)'(1))
                out_code_d = mem_q[rd_ptr_inc];
            else if (push)
                out_code_d = code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_code_q  <= '0;
            prev_idle_q <= 1'b1;
            prev_code_q <= '0;
            overflow_q  <= 1'b0;
        end else begin
            prev_idle_q <= idle;
            if (!idle)
                prev_code_q <= code;
            if (push)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)
                rd_ptr_q <= rd_ptr_inc;
            if (ev && full && !pop)
                overflow_q <= 1'b1;
            count_q    <= count_d;
            out_code_q <= out_code_d;
        end
    end

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (!rst && push)
            mem_q[wr_ptr_q] <= code;
    end

`ifdef CEF_STAMP_EN
    logic [7:0] stamp_cnt_q;
    logic [7:0] stamp_mem_q [DEPTH];
    logic [7:0] out_stamp_q, out_stamp_d;

    assign out_stamp = out_stamp_q;

    always_comb begin
        out_stamp_d = out_stamp_q;
        if (count_q == '0) begin
            if (push)
                out_stamp_d = stamp_cnt_q;
        end else if (pop) begin
            if (count_q > (AW+1)'(1))
                out_stamp_d = stamp_mem_q[rd_ptr_inc];
            else if (push)
                out_stamp_d = stamp_cnt_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stamp_cnt_q <= '0;
            out_stamp_q <= '0;
        end else begin
            stamp_cnt_q <= stamp_cnt_q + 1'b1;
            out_stamp_q <= out_stamp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push)
            stamp_mem_q[wr_ptr_q] <= stamp_cnt_q;
    end
`endif

endmodule

// File: tb/tb_code_event_fifo.sv
// Directed bench for code_event_fifo: inputs change 1 ns after each rising edge and
// outputs are checked in that same settled window.
module tb_code_event_fifo;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       idle = 1'b1;
    logic [2:0] code = 3'd0;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic       full;
    logic [2:0] count;
    logic       overflow;
`ifdef CEF_STAMP_EN
    logic [7:0] out_stamp;
`endif

    int total = 0;
    int bad   = 0;

    code_event_fifo #(.DEPTH(4), .AW(2)) dut (
        .clk(clk), .rst(rst), .idle(idle), .code(code), .out_ready(out_ready),
        .out_valid(out_valid), .out_code(out_code), .full(full), .count(count),
        .overflow(overflow)
`ifdef CEF_STAMP_EN
        , .out_stamp(out_stamp)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic push_codes(input logic [2:0] c0, input logic [2:0] c1, input logic [2:0] c2);
        idle = 1'b0;
        code = c0; tick();
        code = c1; tick();
        code = c2; tick();
    endtask

    initial begin
        // 1: reset then idle
        tick(2);
        rst = 1'b0;
        tick(5);
        check("reset_valid", {7'd0, out_valid}, 8'd0);
        check("reset_count", {5'd0, count}, 8'd0);
        check("reset_ovf", {7'd0, overflow}, 8'd0);
        check("reset_full", {7'd0, full}, 8'd0);
        check("reset_code", {5'd0, out_code}, 8'd0);

        // 2: steady code gives one event, visible right after the sampling edge
        idle = 1'b0; code = 3'd5;
        tick();
        check("lat_valid", {7'd0, out_valid}, 8'd1);
        check("lat_code", {5'd0, out_code}, 8'd5);
        tick(9);
        check("steady_count", {5'd0, count}, 8'd1);
        check("steady_code", {5'd0, out_code}, 8'd5);
        idle = 1'b1; out_ready = 1'b1;
        tick();
        check("drain1_count", {5'd0, count}, 8'd0);
        check("empty_hold_code", {5'd0, out_code}, 8'd5);
        tick(2);
        check("empty_ready_ignored", {5'd0, count}, 8'd0);
        out_ready = 1'b0;

        // 3: 7,6,7 back to back
        push_codes(3'd7, 3'd6, 3'd7);
        idle = 1'b1;
        check("t3_count", {5'd0, count}, 8'd3);
        out_ready = 1'b1;
        check("t3_pop0", {5'd0, out_code}, 8'd7); tick();
        check("t3_pop1", {5'd0, out_code}, 8'd6); tick();
        check("t3_pop2", {5'd0, out_code}, 8'd7); tick();
        check("t3_empty", {7'd0, out_valid}, 8'd0);
        out_ready = 1'b0;

        // 4: five events into DEPTH=4
        push_codes(3'd1, 3'd2, 3'd3);
        code = 3'd4; tick();
        check("t4_full", {7'd0, full}, 8'd1);
        check("t4_no_ovf_yet", {7'd0, overflow}, 8'd0);
        code = 3'd5; tick();
        idle = 1'b1;
        check("t4_count", {5'd0, count}, 8'd4);
        check("t4_ovf", {7'd0, overflow}, 8'd1);
        out_ready = 1'b1;
        check("t4_pop0", {5'd0, out_code}, 8'd1); tick();
        check("t4_pop1", {5'd0, out_code}, 8'd2); tick();
        check("t4_pop2", {5'd0, out_code}, 8'd3); tick();
        check("t4_pop3", {5'd0, out_code}, 8'd4); tick();
        check("t4_empty", {5'd0, count}, 8'd0);
        check("t4_ovf_sticky", {7'd0, overflow}, 8'd1);
        out_ready = 1'b0;

        // 5: full with simultaneous pop and event
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_ovf_cleared", {7'd0, overflow}, 8'd0);
        push_codes(3'd1, 3'd2, 3'd3);
        code = 3'd4; tick();
        check("t5_full", {7'd0, full}, 8'd1);
        code = 3'd6; out_ready = 1'b1; tick();
        idle = 1'b1;
        check("t5_count", {5'd0, count}, 8'd4);
        check("t5_ovf", {7'd0, overflow}, 8'd0);
        check("t5_pop0", {5'd0, out_code}, 8'd2); tick();
        check("t5_pop1", {5'd0, out_code}, 8'd3); tick();
        check("t5_pop2", {5'd0, out_code}, 8'd4); tick();
        check("t5_tail", {5'd0, out_code}, 8'd6); tick();
        check("t5_empty", {5'd0, count}, 8'd0);
        out_ready = 1'b0;

        // 6: reset mid-operation with an event on the reset cycle
        push_codes(3'd1, 3'd2, 3'd3);
        check("t6_pre", {5'd0, count}, 8'd3);
        code = 3'd5; rst = 1'b1; tick();
        rst = 1'b0; idle = 1'b1;
        check("t6_count", {5'd0, count}, 8'd0);
        check("t6_valid", {7'd0, out_valid}, 8'd0);
        check("t6_code", {5'd0, out_code}, 8'd0);
        tick();
        check("t6_not_captured", {5'd0, count}, 8'd0);

        // empty + event + ready: no bypass; then idle->same code is a new event
        idle = 1'b0; code = 3'd2; out_ready = 1'b1; tick();
        check("nobypass_count", {5'd0, count}, 8'd1);
        check("nobypass_code", {5'd0, out_code}, 8'd2);
        idle = 1'b1; tick();
        check("nobypass_popped", {5'd0, count}, 8'd0);
        out_ready = 1'b0;
        idle = 1'b0; code = 3'd2; tick();
        check("reevent_count", {5'd0, count}, 8'd1);
        idle = 1'b1; tick();

`ifdef CEF_STAMP_EN
        rst = 1'b1; tick(); rst = 1'b0;
        check("stamp_reset", out_stamp, 8'd0);
        tick(10);
        idle = 1'b0; code = 3'd3; tick();
        idle = 1'b1; tick();
        idle = 1'b0; tick();
        idle = 1'b1;
        check("stamp_count", {5'd0, count}, 8'd2);
        out_ready = 1'b1;
        check("stamp_a", out_stamp, 8'd10); tick();
        check("stamp_b", out_stamp, 8'd12); tick();
        out_ready = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
